divisor_reg_slave: RTL and testbench



---
 rtl/divisor_reg_pkg.sv | 39 +++
 rtl/divisor_reg_slave_if.sv | 28 ++
 rtl/divisor_reg_slave_wb_wait_responder.sv | 85 ++++++++
 rtl/divisor_reg_slave.sv | 150 +++++++++++++++
 tb/tb_divisor_reg_slave.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/divisor_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divisor_reg_pkg
// Description : Register offsets, STATUS layout and handshake FSM encoding
//               shared by the divisor register slave.
// Revision    : 1.0 - initial release
// ============================================================================
package divisor_reg_pkg;

    localparam logic [1:0] OFS_LO     = 2'd0;
    localparam logic [1:0] OFS_HI     = 2'd1;
    localparam logic [1:0] OFS_STATUS = 2'd2;

    localparam int ST_PEND_LO  = 0;
    localparam int ST_PEND_HI  = 1;
    localparam int ST_ZERO_ERR = 2;
    localparam int ST_CNT_LSB  = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } wb_state_t;

    function automatic logic [31:0] status_word(input logic       pend_lo,
                                                input logic       pend_hi,
                                                input logic       zero_err,
                                                input logic [7:0] cnt);
        logic [31:0] w;
        w                   = '0;
        w[ST_PEND_LO]       = pend_lo;
        w[ST_PEND_HI]       = pend_hi;
        w[ST_ZERO_ERR]      = zero_err;
        w[ST_CNT_LSB +: 8]  = cnt;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/divisor_reg_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : divisor_reg_slave_if
// Description : Wishbone classic-cycle signal bundle (16-bit address, 32-bit
//               data) with master and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface divisor_reg_slave_if;
    logic [15:0] ADR_I;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        WE_I;
    logic        STB_I;
    logic        CYC_I;
    logic        ACK_O;
    logic        ERR_O;

    modport master (
        output ADR_I, DAT_I, WE_I, STB_I, CYC_I,
        input  DAT_O, ACK_O, ERR_O
    );

    modport slave (
        input  ADR_I, DAT_I, WE_I, STB_I, CYC_I,
        output DAT_O, ACK_O, ERR_O
    );
endinterface
`default_nettype wire

// File: rtl/divisor_reg_slave_wb_wait_responder.sv
`default_nettype none
// ============================================================================
// Module      : wb_wait_responder
// Description : IDLE/WAIT/RESP bus handshake with programmable wait states;
//               emits a one-cycle resp strobe plus the latched request.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_wait_responder
    import divisor_reg_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int DATA_W      = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_req,
    input  wire logic              i_cyc,
    input  wire logic              i_stb,
    input  wire logic [15:0]       i_adr,
    input  wire logic              i_we,
    input  wire logic [DATA_W-1:0] i_dat,
    output logic                   o_resp,
    output logic [15:0]            o_adr,
    output logic                   o_we,
    output logic [DATA_W-1:0]      o_dat
);

    localparam logic [2:0] c_LAST = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    wb_state_t          r_state;
    wb_state_t          w_next;
    logic [2:0]         r_cnt;
    logic [15:0]        r_adr;
    logic               r_we;
    logic [DATA_W-1:0]  r_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_adr   <= '0;
            r_we    <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_req) begin
                r_adr <= i_adr;
                r_we  <= i_we;
                r_dat <= i_dat;
                r_cnt <= 3'd0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        o_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req)
                    w_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                // Master withdrawing the cycle abandons the request untouched.
                if (!(i_cyc && i_stb))
                    w_next = S_IDLE;
                else if (r_cnt == c_LAST)
                    w_next = S_RESP;
            end
            S_RESP: begin
                o_resp = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign o_adr = r_adr;
    assign o_we  = r_we;
    assign o_dat = r_dat;

endmodule
`default_nettype wire

// File: rtl/divisor_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : divisor_reg_slave
// Description : Wishbone slave holding the sampling-clock divisor halves and a
//               status word; commits both halves atomically to divisor_out.
// Revision    : 1.0 - initial release
// ============================================================================
module divisor_reg_slave
    import divisor_reg_pkg::*;
#(
    parameter logic [15:0] BASE_ADR    = 16'h400A,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] DEFAULT_DIV = 32'd2
) (
    input  wire logic           CLK_I,
    input  wire logic           RST_I,
    divisor_reg_slave_if.slave  bus,
    output logic [31:0]         divisor_out,
    output logic                divisor_update
);

    localparam logic [15:0] c_ADR_LO = BASE_ADR + {14'd0, OFS_LO};
    localparam logic [15:0] c_ADR_HI = BASE_ADR + {14'd0, OFS_HI};
    localparam logic [15:0] c_ADR_ST = BASE_ADR + {14'd0, OFS_STATUS};

    logic        w_hit;
    logic        w_resp;
    logic [15:0] w_adr;
    logic        w_we;
    logic [15:0] w_dat;
    logic        w_is_lo;
    logic        w_is_hi;
    logic        w_is_st;
    logic [31:0] w_rdata;
    logic [32:0] w_commit_unused;

    logic [15:0] r_shadow_lo;
    logic [15:0] r_shadow_hi;
    logic        r_pend_lo;
    logic        r_pend_hi;
    logic [7:0]  r_commit_cnt;
    logic        r_zero_err;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_dat_o;
    logic [31:0] r_divisor;
    logic        r_update;

    assign w_hit = bus.CYC_I && bus.STB_I &&
                   (bus.ADR_I == c_ADR_LO || bus.ADR_I == c_ADR_HI || bus.ADR_I == c_ADR_ST);

    wb_wait_responder #(
        .WAIT_STATES (WAIT_STATES),
        .DATA_W      (16)
    ) u_resp (
        .clk    (CLK_I),
        .rst    (RST_I),
        .i_req  (w_hit),
        .i_cyc  (bus.CYC_I),
        .i_stb  (bus.STB_I),
        .i_adr  (bus.ADR_I),
        .i_we   (bus.WE_I),
        .i_dat  (bus.DAT_I[15:0]),
        .o_resp (w_resp),
        .o_adr  (w_adr),
        .o_we   (w_we),
        .o_dat  (w_dat)
    );

    assign w_is_lo = (w_adr == c_ADR_LO);
    assign w_is_hi = (w_adr == c_ADR_HI);
    assign w_is_st = (w_adr == c_ADR_ST);
    assign w_commit_unused = '0;

    always_comb begin
        w_rdata = 32'd0;
        if (w_is_lo)
            w_rdata = {16'd0, r_shadow_lo};
        else if (w_is_hi)
            w_rdata = {16'd0, r_shadow_hi};
        else if (w_is_st)
            w_rdata = status_word(r_pend_lo, r_pend_hi, r_zero_err, r_commit_cnt);
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_shadow_lo  <= DEFAULT_DIV[15:0];
            r_shadow_hi  <= DEFAULT_DIV[31:16];
            r_pend_lo    <= 1'b0;
            r_pend_hi    <= 1'b0;
            r_commit_cnt <= 8'd0;
            r_zero_err   <= 1'b0;
            r_ack        <= 1'b0;
            r_err        <= 1'b0;
            r_dat_o      <= 32'd0;
            r_divisor    <= DEFAULT_DIV;
            r_update     <= 1'b0;
        end else begin
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_dat_o  <= 32'd0;
            r_update <= 1'b0;

            if (w_resp) begin
                if (w_we && w_is_st) begin
                    r_err <= 1'b1;
                end else begin
                    r_ack <= 1'b1;
                    if (w_we) begin
                        if (w_is_lo) begin
                            r_shadow_lo <= w_dat;
                            r_pend_lo   <= 1'b1;
                        end
                        if (w_is_hi) begin
                            r_shadow_hi <= w_dat;
                            r_pend_hi   <= 1'b1;
                        end
                    end else begin
                        r_dat_o <= w_rdata;
                        if (w_is_st)
                            r_zero_err <= 1'b0;
                    end
                end
            end

            // A commit never shares an edge with a response, so ordering here
            // only matters for readability: the commit always sees settled flags.
            if (r_pend_lo && r_pend_hi) begin
                r_pend_lo    <= 1'b0;
                r_pend_hi    <= 1'b0;
                r_update     <= 1'b1;
                r_commit_cnt <= r_commit_cnt + 8'd1;
                if ({r_shadow_hi, r_shadow_lo} == 32'd0) begin
                    r_divisor  <= 32'd1;
                    r_zero_err <= 1'b1;
                end else begin
                    r_divisor  <= {r_shadow_hi, r_shadow_lo};
                end
            end
        end
    end

    assign bus.ACK_O      = r_ack;
    assign bus.ERR_O      = r_err;
    assign bus.DAT_O      = r_dat_o;
    assign divisor_out    = r_divisor;
    assign divisor_update = r_update;

endmodule
`default_nettype wire

// File: tb/tb_divisor_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_divisor_reg_slave
// Description : Directed scoreboard bench for divisor_reg_slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divisor_reg_slave;

    localparam int          W      = 1;
    localparam logic [15:0] A_LO   = 16'h400A;
    localparam logic [15:0] A_HI   = 16'h400B;
    localparam logic [15:0] A_ST   = 16'h400C;
    localparam logic [15:0] A_MISS = 16'h4010;

    typedef struct {
        int          cyc;
        bit          err;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        int          cyc;
        logic [31:0] div;
    } upd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] div_out;
    logic        div_upd;

    divisor_reg_slave_if bus ();

    divisor_reg_slave #(
        .BASE_ADR    (16'h400A),
        .WAIT_STATES (W),
        .DEFAULT_DIV (32'd2)
    ) dut (
        .CLK_I          (clk),
        .RST_I          (rst),
        .bus            (bus),
        .divisor_out    (div_out),
        .divisor_update (div_upd)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n = cyc_n + 1;

    rsp_t exp_q[$];
    upd_t upd_q[$];
    rsp_t mon_e;
    upd_t mon_u;

    int n_vec  = 0;
    int n_err  = 0;
    int n_upd  = 0;
    int n_resp = 0;

    logic [15:0] m_lo, m_hi;
    bit          m_plo, m_phi, m_zerr;
    logic [7:0]  m_cnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {16'h0, m_cnt, 5'h0, m_zerr, m_phi, m_plo};
    endfunction

    task automatic model_reset();
        m_lo   = 16'h0002;
        m_hi   = 16'h0000;
        m_plo  = 0;
        m_phi  = 0;
        m_zerr = 0;
        m_cnt  = 8'd0;
    endtask

    // Issues one bus access, predicts response and any commit, then waits for termination.
    task automatic access(input logic [15:0] adr, input bit we, input logic [31:0] dat);
        rsp_t e;
        upd_t u;
        bit   got;
        got = 0;
        @(negedge clk);
        bus.ADR_I = adr;
        bus.WE_I  = we;
        bus.DAT_I = dat;
        bus.CYC_I = 1'b1;
        bus.STB_I = 1'b1;
        e.cyc  = cyc_n + 2 + W;
        e.err  = 0;
        e.data = 32'd0;
        if (adr == A_LO) begin
            if (we) begin m_lo = dat[15:0]; m_plo = 1; end
            else e.data = {16'h0, m_lo};
        end else if (adr == A_HI) begin
            if (we) begin m_hi = dat[15:0]; m_phi = 1; end
            else e.data = {16'h0, m_hi};
        end else begin
            if (we) e.err = 1;
            else begin e.data = m_status(); m_zerr = 0; end
        end
        exp_q.push_back(e);
        if (m_plo && m_phi) begin
            u.cyc = e.cyc + 1;
            if ({m_hi, m_lo} == 32'd0) begin
                u.div  = 32'd1;
                m_zerr = 1;
            end else begin
                u.div = {m_hi, m_lo};
            end
            m_cnt = m_cnt + 8'd1;
            m_plo = 0;
            m_phi = 0;
            upd_q.push_back(u);
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            got = bus.ACK_O | bus.ERR_O;
        end
        check("resp_seen", {31'd0, got}, 32'd1);
        bus.CYC_I = 1'b0;
        bus.STB_I = 1'b0;
        bus.WE_I  = 1'b0;
    endtask

    // Monitor: compares every presented response and every update pulse against the queues.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (bus.ACK_O || bus.ERR_O) begin
                    n_resp++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", {30'd0, bus.ERR_O, bus.ACK_O}, 32'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("resp_cycle", cyc_n, mon_e.cyc);
                        check("ack", {31'd0, bus.ACK_O}, {31'd0, !mon_e.err});
                        check("err", {31'd0, bus.ERR_O}, {31'd0, mon_e.err});
                        check("rdata", bus.DAT_O, mon_e.data);
                    end
                end else begin
                    check("dat_idle", bus.DAT_O, 32'd0);
                end
                if (div_upd) begin
                    n_upd++;
                    if (upd_q.size() == 0) begin
                        check("unexpected_update", {31'd0, div_upd}, 32'd0);
                    end else begin
                        mon_u = upd_q.pop_front();
                        check("update_cycle", cyc_n, mon_u.cyc);
                        check("divisor_out", div_out, mon_u.div);
                    end
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int n0;

    initial begin
        rst       = 1'b1;
        bus.ADR_I = 16'h0;
        bus.DAT_I = 32'h0;
        bus.WE_I  = 1'b0;
        bus.STB_I = 1'b0;
        bus.CYC_I = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ack", {31'd0, bus.ACK_O}, 32'd0);
        check("rst_err", {31'd0, bus.ERR_O}, 32'd0);
        check("rst_div", div_out, 32'd2);
        check("rst_upd", {31'd0, div_upd}, 32'd0);
        access(A_ST, 0, 0);
        access(A_LO, 0, 0);

        // Write pair; upper data half must be ignored.
        access(A_LO, 1, 32'hABCD1234);
        access(A_HI, 1, 32'h00000005);
        access(A_HI, 0, 0);
        check("pair_div", div_out, 32'h00051234);

        // Asynchronous reset landing mid-transaction, away from any edge.
        @(negedge clk);
        bus.ADR_I = A_HI; bus.WE_I = 1'b1; bus.DAT_I = 32'h99; bus.CYC_I = 1'b1; bus.STB_I = 1'b1;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_ack", {31'd0, bus.ACK_O}, 32'd0);
        check("arst_div", div_out, 32'd2);
        check("arst_upd", {31'd0, div_upd}, 32'd0);
        @(negedge clk);
        bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.WE_I = 1'b0;
        rst = 1'b0;
        model_reset();
        access(A_HI, 0, 0);
        access(A_ST, 0, 0);

        // High half alone must not commit.
        n0 = n_upd;
        access(A_HI, 1, 32'd7);
        access(A_ST, 0, 0);
        check("hi_only_no_pulse", n_upd, n0);
        access(A_LO, 1, 32'd3);
        access(A_ST, 0, 0);
        check("hilo_div", div_out, 32'h00070003);

        // Zero divisor forced to 1; sticky flag cleared by STATUS read.
        access(A_LO, 1, 32'd0);
        access(A_HI, 1, 32'd0);
        access(A_ST, 0, 0);
        access(A_ST, 0, 0);
        check("zero_div", div_out, 32'd1);

        // STATUS is read-only.
        access(A_ST, 1, 32'hFFFF);

        // Address miss: no termination of any kind.
        @(negedge clk);
        bus.ADR_I = A_MISS; bus.WE_I = 1'b0; bus.CYC_I = 1'b1; bus.STB_I = 1'b1;
        n0 = n_resp;
        repeat (10) @(posedge clk);
        #1;
        check("miss_no_resp", n_resp, n0);
        bus.CYC_I = 1'b0; bus.STB_I = 1'b0;

        // Cycle dropped during WAIT leaves shadow and pend untouched.
        @(negedge clk);
        bus.ADR_I = A_LO; bus.WE_I = 1'b1; bus.DAT_I = 32'hBEEF; bus.CYC_I = 1'b1; bus.STB_I = 1'b1;
        n0 = n_resp;
        @(posedge clk);
        #1;
        bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.WE_I = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_resp", n_resp, n0);
        access(A_LO, 0, 0);
        access(A_ST, 0, 0);

        // Commit counter wraps after 256 commits.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n0 = n_upd;
        for (int i = 0; i < 256; i++) begin
            access(A_LO, 1, i + 1);
            access(A_HI, 1, i);
        end
        access(A_ST, 0, 0);
        check("wrap_updates", n_upd - n0, 32'd256);

        repeat (3) @(posedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 32'd0);
        check("upd_q_drained", upd_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
